// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-requester round-robin arbiter with grant-hold timeout
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [3:0] req_in,
  input  logic       done_in,
  output logic [3:0] gnt_out,
  output logic [1:0] gnt_id_out,
  output logic       gnt_valid_out,
  output logic       timeout_out
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [1:0]       last_id;

  logic [1:0] win_id;
  logic       win_found;
  logic [1:0] idx;
  logic       rel_done;
  logic       rel_drop;
  logic       rel_to;

  // Search last_id+1 .. last_id+4; descending loop so the nearest hit wins.
  always_comb begin
    win_id    = last_id;
    win_found = 1'b0;
    idx       = last_id;
    for (int k = 4; k >= 1; k--) begin
      idx = last_id + 2'(k);
      if (req_in[idx]) begin
        win_id    = idx;
        win_found = 1'b1;
      end
    end
  end

  assign rel_done = done_in;
  assign rel_drop = ~req_in[gnt_id_out];
  assign rel_to   = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      last_id       <= 2'd3;
      gnt_out       <= 4'b0000;
      gnt_id_out    <= 2'd0;
      gnt_valid_out <= 1'b0;
      timeout_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout_out <= 1'b0;
          hold_cnt    <= '0;
          if (win_found) begin
            state         <= GRANT;
            gnt_out       <= 4'b0001 << win_id;
            gnt_id_out    <= win_id;
            gnt_valid_out <= 1'b1;
          end
        end
        GRANT: begin
          if (rel_done || rel_drop || rel_to) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            last_id       <= gnt_id_out;
            gnt_out       <= 4'b0000;
            gnt_id_out    <= 2'd0;
            gnt_valid_out <= 1'b0;
            // A voluntary release wins over a coincident timeout.
            timeout_out   <= rel_to && !rel_done && !rel_drop;
          end else begin
            hold_cnt    <= hold_cnt + 1'b1;
            timeout_out <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          gnt_out       <= 4'b0000;
          gnt_id_out    <= 2'd0;
          gnt_valid_out <= 1'b0;
          timeout_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - directed self-checking bench for rr_arbiter_4
module tb_rr_arbiter_4;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [3:0] req_in;
  logic       done_in;
  logic [3:0] gnt_out;
  logic [1:0] gnt_id_out;
  logic       gnt_valid_out;
  logic       timeout_out;

  int passed = 0;
  int total  = 0;

  rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_in        (req_in),
    .done_in       (done_in),
    .gnt_out       (gnt_out),
    .gnt_id_out    (gnt_id_out),
    .gnt_valid_out (gnt_valid_out),
    .timeout_out   (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                           input logic to);
    check({tag, ".gnt"}, {4'b0, gnt_out}, {4'b0, g});
    check({tag, ".id"}, {6'b0, gnt_id_out}, {6'b0, id});
    check({tag, ".valid"}, {7'b0, gnt_valid_out}, {7'b0, (g != 4'b0)});
    check({tag, ".timeout"}, {7'b0, timeout_out}, {7'b0, to});
  endtask

  initial begin
    // Reset with all requesting
    rst_n_in = 1'b0; req_in = 4'b1111; done_in = 1'b0;
    tick(); tick();
    check_all("reset", 4'b0000, 2'd0, 1'b0);
    req_in = 4'b0000; rst_n_in = 1'b1;
    tick();
    check_all("idle_no_req", 4'b0000, 2'd0, 1'b0);

    // Single requester, done release, regrant after gap
    req_in = 4'b0100;
    tick(); check_all("single_grant", 4'b0100, 2'd2, 1'b0);
    done_in = 1'b1;
    tick(); check_all("single_done", 4'b0000, 2'd0, 1'b0);
    done_in = 1'b0;
    tick(); check_all("single_regrant", 4'b0100, 2'd2, 1'b0);
    req_in = 4'b0000;
    tick(); check_all("single_drop", 4'b0000, 2'd0, 1'b0);

    // Rotation from reset pointer: 0,1,2,3,0
    rst_n_in = 1'b0; tick(); rst_n_in = 1'b1;
    req_in = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick(); check_all($sformatf("rot_grant%0d", i), 4'b0001 << (i % 4), 2'(i % 4), 1'b0);
      done_in = 1'b1;
      tick(); check_all($sformatf("rot_gap%0d", i), 4'b0000, 2'd0, 1'b0);
      done_in = 1'b0;
    end

    // Timeout after exactly 8 grant cycles, then req1
    rst_n_in = 1'b0; req_in = 4'b0000; tick(); rst_n_in = 1'b1;
    req_in = 4'b0011;
    tick(); check_all("to_grant", 4'b0001, 2'd0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick(); check_all($sformatf("to_hold%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    tick(); check_all("to_release", 4'b0000, 2'd0, 1'b1);
    tick(); check_all("to_next", 4'b0010, 2'd1, 1'b0);
    req_in = 4'b0000;
    tick(); check_all("to_next_drop", 4'b0000, 2'd0, 1'b0);

    // Owner 3 drops request; pointer then starts at 0
    req_in = 4'b1000;
    tick(); check_all("drop_grant", 4'b1000, 2'd3, 1'b0);
    tick(); check_all("drop_hold", 4'b1000, 2'd3, 1'b0);
    req_in = 4'b0111;
    tick(); check_all("drop_release", 4'b0000, 2'd0, 1'b0);
    tick(); check_all("drop_next", 4'b0001, 2'd0, 1'b0);
    req_in = 4'b0000;
    tick(); check_all("drop_next_rel", 4'b0000, 2'd0, 1'b0);

    // done coincident with the timeout cycle: no pulse
    req_in = 4'b0010;
    tick(); check_all("both_grant", 4'b0010, 2'd1, 1'b0);
    for (int i = 1; i < 8; i++) tick();
    check_all("both_last", 4'b0010, 2'd1, 1'b0);
    done_in = 1'b1;
    tick(); check_all("both_release", 4'b0000, 2'd0, 1'b0);
    done_in = 1'b0; req_in = 4'b0000;
    tick();

    // Reset mid-grant, then pointer back to 3
    req_in = 4'b0010;
    tick(); check_all("mid_grant", 4'b0010, 2'd1, 1'b0);
    rst_n_in = 1'b0;
    tick(); check_all("mid_reset", 4'b0000, 2'd0, 1'b0);
    rst_n_in = 1'b1; req_in = 4'b1010;
    tick(); check_all("mid_after", 4'b0010, 2'd1, 1'b0);
    req_in = 4'b1001; done_in = 1'b1;
    tick(); done_in = 1'b0;
    tick(); check_all("mid_rotate", 4'b1000, 2'd3, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
